// File: rtl/spi_xfer_scheduler.sv
// spi_xfer_scheduler: round-robin arbiter feeding two requesters
// into one SPI engine, with freq settle, gap and response hold.
// Ports: clk, reset (async low); req0/req1 valid/ready/data/freq;
// rsp valid/ready/data/id/timeout; eng start/freq/tx/rx/done; busy.
// Option: define SPI_SCHED_TIMEOUT_EN to abort WAIT after
// TIMEOUT_CYCLES with rsp_timeout=1 and rsp_data=0.
module spi_xfer_scheduler #(
  parameter int GAP_CYCLES     = 10,
  parameter int SETTLE_CYCLES  = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  input  logic [1:0]  req0_freq,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  input  logic [1:0]  req1_freq,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_id,
  output logic        rsp_timeout,
  output logic        eng_rx_start,
  output logic        eng_tx_start,
  output logic [1:0]  eng_freq_control,
  output logic [15:0] eng_tx_data,
  input  logic [15:0] eng_rx_data,
  input  logic        eng_rx_valid,
  input  logic        eng_tx_done,
  output logic        busy
);

  localparam int M1 =
    (GAP_CYCLES > SETTLE_CYCLES) ? GAP_CYCLES : SETTLE_CYCLES;
  localparam int MAXC =
    (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE, ARB, SETTLE, START, WAIT, RESP, GAP
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic          cnt_run;
  logic          last_gnt;
  logic          gnt;
  logic          gnt_id;
  logic [1:0]    gnt_freq;
  logic          any_req;
  logic          tx_seen, rx_seen;
  logic          tx_ok, rx_ok, done_now;
  logic          to_hit;
  logic [15:0]   rx_buf;

  assign any_req = req0_valid | req1_valid;
  // Both pending: the one not granted last wins.
  assign gnt = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
  assign gnt_freq = gnt ? req1_freq : req0_freq;

  assign tx_ok    = tx_seen | eng_tx_done;
  assign rx_ok    = rx_seen | eng_rx_valid;
  assign done_now = tx_ok & rx_ok;

  assign busy = (state != IDLE);

`ifdef SPI_SCHED_TIMEOUT_EN
  assign to_hit = (state == WAIT) && !done_now &&
                  (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_run = (state == state_nx) &&
                   (state == SETTLE || state == GAP ||
                    state == WAIT);
`else
  assign to_hit = 1'b0;
  assign rsp_timeout = 1'b0;
  assign cnt_run = (state == state_nx) &&
                   (state == SETTLE || state == GAP);
`endif

  always_comb begin
    state_nx     = state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    eng_rx_start = 1'b0;
    eng_tx_start = 1'b0;
    unique case (state)
      IDLE: if (any_req) state_nx = ARB;
      ARB: begin
        if (!any_req) begin
          state_nx = IDLE;
        end else begin
          req0_ready = !gnt;
          req1_ready = gnt;
          state_nx = (gnt_freq != eng_freq_control) ? SETTLE : START;
        end
      end
      SETTLE: begin
        if (cnt == CW'(SETTLE_CYCLES - 1)) state_nx = START;
      end
      START: begin
        eng_rx_start = 1'b1;
        eng_tx_start = 1'b1;
        state_nx = WAIT;
      end
      WAIT: if (done_now || to_hit) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = GAP;
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      last_gnt         <= 1'b1;
      gnt_id           <= 1'b0;
      eng_tx_data      <= '0;
      eng_freq_control <= 2'b01;
      tx_seen          <= 1'b0;
      rx_seen          <= 1'b0;
      rx_buf           <= '0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_id           <= 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
      rsp_timeout      <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_run ? cnt + 1'b1 : '0;

      if (state == ARB && any_req) begin
        last_gnt    <= gnt;
        gnt_id      <= gnt;
        eng_tx_data <= gnt ? req1_data : req0_data;
        if (gnt_freq != eng_freq_control)
          eng_freq_control <= gnt_freq;
      end

      // Flags only count while waiting; cleared on leaving WAIT.
      tx_seen <= (state == WAIT) && tx_ok;
      rx_seen <= (state == WAIT) && rx_ok;
      if (state == WAIT && eng_rx_valid && !rx_seen)
        rx_buf <= eng_rx_data;

      if (state == WAIT && state_nx == RESP) begin
        rsp_valid <= 1'b1;
        rsp_id    <= gnt_id;
        rsp_data  <= to_hit ? 16'h0000 :
                     (rx_seen ? rx_buf : eng_rx_data);
`ifdef SPI_SCHED_TIMEOUT_EN
        rsp_timeout <= to_hit;
`endif
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Bench for spi_xfer_scheduler: directed transfers, scoreboard
// queue of expected responses, monitor pops on rsp handshake.
module tb_spi_xfer_scheduler;

  localparam int GAP = 10;
  localparam int SETTLE = 10;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_data = '0, req1_data = '0;
  logic [1:0]  req0_freq = 2'b01, req1_freq = 2'b01;
  logic        req0_ready, req1_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        rsp_id, rsp_timeout;
  logic        eng_rx_start, eng_tx_start;
  logic [1:0]  eng_freq_control;
  logic [15:0] eng_tx_data;
  logic [15:0] eng_rx_data = '0;
  logic        eng_rx_valid = 1'b0, eng_tx_done = 1'b0;
  logic        busy;

  spi_xfer_scheduler #(
    .GAP_CYCLES(GAP),
    .SETTLE_CYCLES(SETTLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data),
    .req0_freq(req0_freq), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data),
    .req1_freq(req1_freq), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_timeout(rsp_timeout),
    .eng_rx_start(eng_rx_start), .eng_tx_start(eng_tx_start),
    .eng_freq_control(eng_freq_control),
    .eng_tx_data(eng_tx_data), .eng_rx_data(eng_rx_data),
    .eng_rx_valid(eng_rx_valid), .eng_tx_done(eng_tx_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
    logic        tmo;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, gnt_cyc = 0, n_rsp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      n_rsp++;
      acc_cyc = cyc;
      if (q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        e = q.pop_front();
        check("rsp_id", rsp_id, e.id);
        check("rsp_data", rsp_data, e.data);
        check("rsp_timeout", rsp_timeout, e.tmo);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns on the negedge of the cycle after the ARB cycle.
  task automatic grant(input logic id, input logic drop,
                       input string nm);
    int k = 0;
    @(negedge clk);
    while (!(req0_ready || req1_ready) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_gnt"}, {req1_ready, req0_ready},
          id ? 2'b10 : 2'b01);
    gnt_cyc = cyc;
    tick();
    if (drop) begin
      if (id) req1_valid = 1'b0;
      else req0_valid = 1'b0;
    end
    @(negedge clk);
    check({nm, "_rdy_pulse"}, {req1_ready, req0_ready}, 0);
  endtask

  task automatic wait_start(input int exp_n, input logic [15:0] tx,
                            input string nm);
    int n = 1;
    while (!eng_tx_start && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_start_lat"}, n, exp_n);
    check({nm, "_start_pair"}, {eng_rx_start, eng_tx_start}, 2'b11);
    check({nm, "_tx_data"}, eng_tx_data, tx);
  endtask

  // Called on the START negedge; mode 0 same cycle, 1 tx first,
  // 2 rx first (rx_data changes afterwards).
  task automatic engine(input int mode, input logic [15:0] rx,
                        input logic id, input logic [15:0] tx,
                        input string nm);
    q.push_back('{id: id, data: rx, tmo: 1'b0});
    @(negedge clk);
    check({nm, "_start_1cyc"}, {eng_rx_start, eng_tx_start}, 0);
    tick();
    case (mode)
      0: begin
        eng_tx_done = 1'b1;
        eng_rx_valid = 1'b1;
        eng_rx_data = rx;
        tick();
      end
      1: begin
        eng_tx_done = 1'b1;
        tick();
        eng_tx_done = 1'b0;
        repeat (4) tick();
        check({nm, "_tx_hold"}, eng_tx_data, tx);
        eng_rx_valid = 1'b1;
        eng_rx_data = rx;
        tick();
      end
      default: begin
        eng_rx_valid = 1'b1;
        eng_rx_data = rx;
        tick();
        eng_rx_valid = 1'b0;
        eng_rx_data = 16'hDEAD;
        repeat (3) tick();
        eng_tx_done = 1'b1;
        tick();
      end
    endcase
    eng_tx_done = 1'b0;
    eng_rx_valid = 1'b0;
    eng_rx_data = '0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    @(negedge clk);
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_idle"}, busy, 0);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_ctl"},
          {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_timeout,
           eng_rx_start, eng_tx_start, busy}, 8'h00);
    check({nm, "_data"}, {rsp_data, eng_tx_data}, 32'h0);
    check({nm, "_freq"}, eng_freq_control, 2'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    logic [17:0] snap;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    tick();
    reset = 1'b1;
    tick();

    // Single request, no freq change.
    req0_data = 16'h55AA;
    req0_freq = 2'b01;
    req0_valid = 1'b1;
    grant(0, 1, "t1");
    wait_start(1, 16'h55AA, "t1");
    engine(0, 16'h55AA, 0, 16'h55AA, "t1");
    wait_idle("t1");

    // Stray engine flags outside WAIT are ignored.
    eng_tx_done = 1'b1;
    eng_rx_valid = 1'b1;
    tick();
    eng_tx_done = 1'b0;
    eng_rx_valid = 1'b0;
    @(negedge clk);
    check("stray_busy", busy, 0);

    // Simultaneous requests after reset: 0,1,0,1.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    req0_data = 16'hA55A;
    req1_data = 16'h1234;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    grant(0, 0, "t2a");
    wait_start(1, 16'hA55A, "t2a");
    engine(0, 16'hA55A, 0, 16'hA55A, "t2a");
    grant(1, 0, "t2b");
    check("t2b_gap", gnt_cyc - acc_cyc, GAP + 2);
    wait_start(1, 16'h1234, "t2b");
    engine(1, 16'h1234, 1, 16'h1234, "t2b");
    grant(0, 0, "t2c");
    wait_start(1, 16'hA55A, "t2c");
    engine(2, 16'h0A0A, 0, 16'hA55A, "t2c");
    grant(1, 1, "t2d");
    req0_valid = 1'b0;
    wait_start(1, 16'h1234, "t2d");
    engine(0, 16'h4321, 1, 16'h1234, "t2d");
    wait_idle("t2");

    // Frequency change on req1.
    req1_data = 16'hBEEF;
    req1_freq = 2'b11;
    req1_valid = 1'b1;
    grant(1, 1, "t3");
    check("t3_freq", eng_freq_control, 2'b11);
    wait_start(SETTLE + 1, 16'hBEEF, "t3");
    engine(0, 16'hC3C3, 1, 16'hBEEF, "t3");
    wait_idle("t3");

    // Completion orders.
    req1_data = 16'h0F0F;
    req1_valid = 1'b1;
    grant(1, 1, "t4a");
    wait_start(1, 16'h0F0F, "t4a");
    engine(1, 16'h1111, 1, 16'h0F0F, "t4a");
    wait_idle("t4a");
    req0_data = 16'hF0F0;
    req0_freq = 2'b01;
    req0_valid = 1'b1;
    grant(0, 1, "t4b");
    check("t4b_freq", eng_freq_control, 2'b01);
    wait_start(SETTLE + 1, 16'hF0F0, "t4b");
    engine(2, 16'h2222, 0, 16'hF0F0, "t4b");
    wait_idle("t4b");
    req0_data = 16'h3C3C;
    req0_valid = 1'b1;
    grant(0, 1, "t4c");
    wait_start(1, 16'h3C3C, "t4c");
    engine(0, 16'h3333, 0, 16'h3C3C, "t4c");
    wait_idle("t4c");

    // Backpressure: response held 20 cycles, no grant.
    rsp_ready = 1'b0;
    req0_data = 16'h7777;
    req0_valid = 1'b1;
    grant(0, 1, "t5");
    wait_start(1, 16'h7777, "t5");
    engine(0, 16'h7E7E, 0, 16'h7777, "t5");
    req1_freq = 2'b01;
    req1_valid = 1'b1;
    @(negedge clk);
    check("t5_rsp_valid", rsp_valid, 1);
    snap = {rsp_valid, rsp_id, rsp_data};
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if ({rsp_valid, rsp_id, rsp_data} !== snap) bad++;
      if (req0_ready || req1_ready) bad++;
    end
    check("t5_stable_nogrant", bad, 0);
    tick();
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("t5");

    // Reset during WAIT.
    req0_data = 16'h9999;
    req0_valid = 1'b1;
    grant(0, 1, "t6");
    wait_start(1, 16'h9999, "t6");
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_reset_vals("t6_rst");
    eng_tx_done = 1'b1;
    eng_rx_valid = 1'b1;
    eng_rx_data = 16'hAAAA;
    tick();
    eng_tx_done = 1'b0;
    eng_rx_valid = 1'b0;
    tick();
    reset = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid || busy) bad++;
    end
    check("t6_no_rsp", bad, 0);

`ifdef SPI_SCHED_TIMEOUT_EN
    // Engine never completes.
    req0_data = 16'h4444;
    req0_valid = 1'b1;
    grant(0, 1, "t7");
    wait_start(1, 16'h4444, "t7");
    q.push_back('{id: 1'b0, data: 16'h0000, tmo: 1'b1});
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t7_tmo_lat", n, TMO + 1);
    wait_idle("t7");
    check("n_rsp", n_rsp, 11);
`else
    n = 0;
    check("n_rsp", n_rsp + n, 10);
`endif

    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_xfer_scheduler.md
SPI_XFER_SCHEDULER -- requirements
Module: spi_xfer_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 10: idle cycles enforced after each transfer, before the next grant.
REQ-002 Parameter SETTLE_CYCLES, default 10: wait cycles after an eng_freq_control change, before the start pulse.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096: WAIT-state limit, used only when SPI_SCHED_TIMEOUT_EN is defined.
REQ-004 clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req0_valid/req1_valid  input  1  requester n has a transfer pending.
REQ-007 req0_data/req1_data  input  16  transmit word of requester n.
REQ-008 req0_freq/req1_freq  input  2  freq_control code requested by requester n.
REQ-009 req0_ready/req1_ready  output  1  one-cycle accept strobe; the request is consumed when valid&&ready.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_data  output  16  received word.
REQ-013 rsp_id  output  1  index of the requester the response belongs to.
REQ-014 rsp_timeout  output  1  the transfer was aborted by timeout.
REQ-015 eng_rx_start/eng_tx_start  output  1  start pulses to the SPI engine.
REQ-016 eng_freq_control  output  2  clock-divider select to the engine.
REQ-017 eng_tx_data  output  16  word presented to the engine.
REQ-018 eng_rx_data  input  16  engine received word.
REQ-019 eng_rx_valid/eng_tx_done  input  1  engine completion flags.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, ARB, SETTLE, START, WAIT, RESP and GAP.
REQ-022 IDLE SHALL move to ARB on the cycle after any reqN_valid is high.
REQ-023 ARB SHALL grant using round-robin:
- with both requesters valid, the one not granted last wins;
- with one valid, that one wins;
- after reset, req0 has priority.
REQ-024 In ARB, reqN_ready SHALL pulse for exactly one cycle, and data/freq/id SHALL be latched on that cycle.
REQ-025 If the latched freq differs from eng_freq_control, ARB→SETTLE, eng_freq_control updates on entry, and SETTLE lasts SETTLE_CYCLES cycles; otherwise ARB→START directly.
REQ-026 START SHALL assert eng_rx_start and eng_tx_start together for exactly one cycle, then enter WAIT.
REQ-027 eng_tx_data SHALL hold the latched word from ARB through the end of WAIT.
REQ-028 In WAIT, eng_tx_done and eng_rx_valid SHALL each be latched independently; completion is both latched, in any order or on the same cycle.
REQ-029 On completion the block SHALL capture eng_rx_data, set rsp_valid=1 and rsp_timeout=0, and enter RESP.
REQ-030 RESP SHALL hold rsp_valid, rsp_data, rsp_id and rsp_timeout stable until rsp_ready; the transfer then enters GAP.
REQ-031 A response is accepted on the first cycle of rsp_valid if rsp_ready is already high; rsp_valid then clears on the next edge.
REQ-032 GAP SHALL last GAP_CYCLES cycles and then return to IDLE; requests arriving in GAP wait, and ready is never asserted outside ARB.
REQ-033 Engine flags arriving outside WAIT SHALL be ignored.
REQ-034 A requester deasserting valid before its grant SHALL lose the request without error.

Reset
REQ-035 While reset=0, the block SHALL hold:
- state=IDLE;
- req0_ready=req1_ready=0 and rsp_valid=0;
- rsp_data=0, rsp_id=0, rsp_timeout=0;
- eng_rx_start=eng_tx_start=0 and eng_tx_data=0;
- eng_freq_control=2'b01;
- busy=0 and the last-grant pointer set to req1, so req0 wins first.
REQ-036 Reset asserted mid-transfer SHALL abort immediately with no response, and the completion latches clear.

Configuration
REQ-037 With SPI_SCHED_TIMEOUT_EN defined, a counter SHALL run in WAIT.
REQ-038 If completion is not reached within TIMEOUT_CYCLES, the block SHALL enter RESP with rsp_data=0, rsp_timeout=1 and rsp_id of the aborted requester.
REQ-039 Without SPI_SCHED_TIMEOUT_EN, WAIT SHALL wait indefinitely, rsp_timeout SHALL be tied 0, and no counter is built.

Verification
REQ-040 Single request, no freq change: req0 data 16'h55AA, freq 2'b01.
- Expect req0_ready pulse, then a one-cycle start pair.
- Engine returns 16'h55AA → rsp_data=16'h55AA, rsp_id=0.
REQ-041 Simultaneous requests, both valid: req0=16'hA55A and req1=16'h1234.
- Expect req0 served first, then req1 after GAP_CYCLES.
- Repeat: the order alternates.
REQ-042 Frequency change: req1 with freq 2'b11.
- Expect eng_freq_control=2'b11, then exactly 10 cycles before the start pulse.
REQ-043 Completion order: tx_done 5 cycles before rx_valid, then rx_valid before tx_done, then both on the same cycle.
- Expect exactly one response in every case.
REQ-044 Backpressure and reset: hold rsp_ready=0 for 20 cycles.
- rsp fields stay stable and no new grant is issued.
- Then drop reset during WAIT: all outputs return to reset values and no response is issued.
REQ-045 With SPI_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=64, the engine never completes.
- Expect rsp_timeout=1 and rsp_data=0 on cycle 64 of WAIT.
